// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_pkg
//  Brief   : Shared constants and types for the MEM pipeline stage.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = LANE_W * NUM_LANES;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // MEM/WB bundle as seen by the write-back stage (valid kept separately)
  typedef struct packed {
    logic [DATA_W-1:0] fromplw;
    logic [1:0]        lastsize;
    logic              signlw;
    logic [DATA_W-1:0] paddans;
    logic              memtoreg;
    logic [DATA_W-1:0] alinkpc;
    logic              linksig;
    logic              regwrite;
    logic [4:0]        writereg;
    logic              fault;
  } wb_bundle_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lane_align
//  Brief   : Combinational lane logic: alignment fault, byte enables,
//            store-lane replication and load right-alignment.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]           req_off_i,
  input  logic [1:0]           size_i,
  input  logic [DATA_W-1:0]    st_data_i,
  input  logic [1:0]           ld_off_i,
  input  logic [DATA_W-1:0]    ld_rdata_i,
  output logic                 fault_o,
  output logic [NUM_LANES-1:0] be_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [DATA_W-1:0]    ld_data_o
);

  // Decode size/offset into fault, lane enables and replicated store data
  always_comb begin
    fault_o = 1'b0;
    be_o    = '0;
    wdata_o = st_data_i;
    case (size_i)
      SZ_WORD: begin
        fault_o = (req_off_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
      SZ_HALF: begin
        fault_o = req_off_i[0];
        be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_BYTE: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

  // Loaded word shifted so the addressed byte lands in lane 0
  assign ld_data_o = ld_rdata_i >> {ld_off_i, 3'b000};

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_stage
//  Brief   : MEM pipeline stage: issues loads/stores over a req/ack bus,
//            stalls upstream while in flight, registers the MEM/WB bundle.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_invalid,
  input  logic [31:0] MEM_inaddANS,
  input  logic [31:0] MEM_instoredata,
  input  logic        MEM_inMEMREAD,
  input  logic        MEM_inMEMWRITE,
  input  logic [1:0]  MEM_inSIZE,
  input  logic        MEM_insignLW,
  input  logic        MEM_inMEMTOREG,
  input  logic        MEM_inREGWRITE,
  input  logic [4:0]  MEM_inWRITEREG,
  input  logic [31:0] MEM_inALINKPC,
  input  logic        MEM_inLINKSIG,
  output logic        MEM_outSTALL,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        WB_outvalid,
  output logic [31:0] WB_outfromplw,
  output logic [1:0]  WB_outLASTSIZE,
  output logic        WB_outsignLW,
  output logic [31:0] WB_outpaddANS,
  output logic        WB_outpMEMTOREG,
  output logic [31:0] WB_outALINKPC,
  output logic        WB_outLINKSIG,
  output logic        WB_outREGWRITE,
  output logic [4:0]  WB_outWRITEREG,
  output logic        WB_outFAULT
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             rd_q, rd_d;
  logic             regwr_q, regwr_d;
  wb_bundle_t       wb_q, wb_d;
  logic             wb_valid_q, wb_valid_d;

  logic             w_fault, w_memop, w_stall;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld_data;
  wb_bundle_t       w_in;

  mem_lane_align u_align (
    .req_off_i  (MEM_inaddANS[1:0]),
    .size_i     (MEM_inSIZE),
    .st_data_i  (MEM_instoredata),
    .ld_off_i   (addr_q[1:0]),
    .ld_rdata_i (dmem_rdata),
    .fault_o    (w_fault),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .ld_data_o  (w_ld_data)
  );

  assign w_memop = MEM_inMEMREAD | MEM_inMEMWRITE;

  // Incoming bundle; load data, regwrite and fault are decided per path
  assign w_in = '{fromplw:  '0,
                  lastsize: MEM_inSIZE,
                  signlw:   MEM_insignLW,
                  paddans:  MEM_inaddANS,
                  memtoreg: MEM_inMEMTOREG,
                  alinkpc:  MEM_inALINKPC,
                  linksig:  MEM_inLINKSIG,
                  regwrite: 1'b0,
                  writereg: MEM_inWRITEREG,
                  fault:    1'b0};

  // Next-state, request latch, MEM/WB update and upstream stall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rd_d        = rd_q;
    regwr_d     = regwr_q;
    wb_d        = wb_q;
    wb_d.regwrite = 1'b0;
    wb_valid_d  = 1'b0;
    w_stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MEM_invalid) begin
          wb_d = w_in;
          if (w_memop && w_fault) begin
            // Misaligned/illegal access never reaches the bus
            wb_valid_d = 1'b1;
            wb_d.fault = 1'b1;
          end else if (w_memop) begin
            w_stall = 1'b1;
            addr_d  = MEM_inaddANS;
            be_d    = w_be;
            wdata_d = w_wdata;
            we_d    = MEM_inMEMWRITE;
            rd_d    = MEM_inMEMREAD;
            regwr_d = MEM_inREGWRITE;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            wb_valid_d    = 1'b1;
            wb_d.regwrite = MEM_inREGWRITE;
          end
        end
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        w_stall = 1'b1;
        if (dmem_ack) begin
          // Ack takes priority over a coincident timeout
          w_stall       = 1'b0;
          wb_valid_d    = 1'b1;
          wb_d.fromplw  = rd_q ? w_ld_data : '0;
          wb_d.regwrite = regwr_q;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          w_stall    = 1'b0;
          wb_valid_d = 1'b1;
          wb_d.fault = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and MEM/WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      regwr_q    <= 1'b0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      regwr_q    <= regwr_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign MEM_outSTALL    = w_stall;
  assign dmem_req        = (state_q == ST_WAIT);
  assign dmem_we         = we_q;
  assign dmem_addr       = {addr_q[31:2], 2'b00};
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;

  assign WB_outvalid     = wb_valid_q;
  assign WB_outfromplw   = wb_q.fromplw;
  assign WB_outLASTSIZE  = wb_q.lastsize;
  assign WB_outsignLW    = wb_q.signlw;
  assign WB_outpaddANS   = wb_q.paddans;
  assign WB_outpMEMTOREG = wb_q.memtoreg;
  assign WB_outALINKPC   = wb_q.alinkpc;
  assign WB_outLINKSIG   = wb_q.linksig;
  assign WB_outREGWRITE  = wb_q.regwrite;
  assign WB_outWRITEREG  = wb_q.writereg;
  assign WB_outFAULT     = wb_q.fault;

endmodule
`default_nettype wire
